// File: rtl/elevator_scheduler_pkg.sv
// Shared types and helpers for the 4-floor elevator scheduler.
// Every per-floor vector is 4 bits wide, with bit i standing for floor i.
package elevator_pkg;

  localparam int FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Floors strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic [FLOORS-1:0] ahead_mask(input floor_t f, input logic up);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) begin
      m[i] = up ? (i > int'(f)) : (i < int'(f));
    end
    return m;
  endfunction

endpackage

// File: rtl/elevator_scheduler_door_timer.sv
// Door dwell counter: load/reload to DOOR_CYCLES-1, count down to zero, then hold.
// done_o goes high while the count is zero.
module door_timer #(
  parameter int DOOR_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DOOR_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load or reload overrides the decrement, so the counter never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_INIT;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-control sequencer for a 4-floor car: holds the call registers,
// steps the floor on arrival pulses, drives the motor and times the door.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int DOOR_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_up,
  input  logic [2:0] hall_down,
  input  logic [3:0] cab_call,
  input  logic       arrive,
  input  logic       door_obstruct,
  output logic [1:0] current_floor,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic       dir_up,
  output logic [2:0] lamp_up,
  output logic [2:0] lamp_down,
  output logic [3:0] lamp_cab
);

  // Hall lamps are kept floor-indexed; the bit with no physical button stays zero.
  localparam logic [FLOORS-1:0] UP_VALID   = 4'b0111;
  localparam logic [FLOORS-1:0] DOWN_VALID = 4'b1110;

  state_e            state_q, state_d;
  floor_t            floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] up_q, up_d, down_q, down_d, cab_q, cab_d;
  logic [FLOORS-1:0] up_clr, down_clr, cab_clr;
  logic [FLOORS-1:0] up_in, down_in;
  logic [FLOORS-1:0] up_sup, down_sup, cab_sup;
  logic [FLOORS-1:0] any_call, here;
  logic              in_door, call_sup;
  logic              door_load, door_done;

  floor_t            arr_floor;
  logic [FLOORS-1:0] arr_here;
  logic              arr_stop_dir, arr_none_ahead;
  logic              here_dir, here_opp;

  assign up_in    = {1'b0, hall_up};
  assign down_in  = {hall_down, 1'b0};
  assign any_call = up_q | down_q | cab_q;
  assign here     = 4'b0001 << floor_q;
  assign in_door  = (state_q == ST_DOOR_OPEN);

  // With the door open, calls at this floor that the open door already serves are swallowed.
  assign cab_sup  = in_door ? (cab_call & here) : '0;
  assign up_sup   = (in_door && dir_q)  ? (up_in & here)   : '0;
  assign down_sup = (in_door && !dir_q) ? (down_in & here) : '0;
  assign call_sup = |(cab_sup | up_sup | down_sup);

  assign up_d   = (up_q   | (up_in   & ~up_sup))   & ~up_clr   & UP_VALID;
  assign down_d = (down_q | (down_in & ~down_sup)) & ~down_clr & DOWN_VALID;
  assign cab_d  = (cab_q  | (cab_call & ~cab_sup)) & ~cab_clr;

  assign here_dir = dir_q ? up_q[floor_q] : down_q[floor_q];
  assign here_opp = dir_q ? down_q[floor_q] : up_q[floor_q];

  // Floor reached by an arrive pulse, saturated at the shaft ends.
  always_comb begin
    arr_floor = floor_q;
    if (dir_q && (floor_q != 2'd3)) begin
      arr_floor = floor_q + 2'd1;
    end else if (!dir_q && (floor_q != 2'd0)) begin
      arr_floor = floor_q - 2'd1;
    end
  end

  assign arr_here       = 4'b0001 << arr_floor;
  assign arr_stop_dir   = dir_q ? up_q[arr_floor] : down_q[arr_floor];
  assign arr_none_ahead = ~|(any_call & ahead_mask(arr_floor, dir_q));

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    up_clr    = '0;
    down_clr  = '0;
    cab_clr   = '0;
    door_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|any_call) begin
          if (cab_q[floor_q] || here_dir) begin
            state_d   = ST_DOOR_OPEN;
            door_load = 1'b1;
            cab_clr   = here;
            if (dir_q) up_clr = here;
            else       down_clr = here;
          end else if (here_opp) begin
            state_d   = ST_DOOR_OPEN;
            door_load = 1'b1;
            dir_d     = !dir_q;
            if (dir_q) down_clr = here;
            else       up_clr = here;
          end else if (|(any_call & ahead_mask(floor_q, dir_q))) begin
            state_d = ST_MOVING;
          end else begin
            dir_d   = !dir_q;
            state_d = ST_MOVING;
          end
        end
      end
      ST_MOVING: begin
        if (arrive) begin
          floor_d = arr_floor;
          if (cab_q[arr_floor] || arr_stop_dir || arr_none_ahead) begin
            state_d   = ST_DOOR_OPEN;
            door_load = 1'b1;
            cab_clr   = arr_here;
            // Turning around only when no call in the travel direction is waiting here.
            if (arr_none_ahead && !arr_stop_dir) begin
              dir_d    = !dir_q;
              up_clr   = arr_here;
              down_clr = arr_here;
            end else if (dir_q) begin
              up_clr = arr_here;
            end else begin
              down_clr = arr_here;
            end
          end
        end
      end
      ST_DOOR_OPEN: begin
        if (door_done && !door_obstruct && !call_sup) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (door_load || (in_door && (door_obstruct || call_sup))),
    .dec_i  (in_door),
    .done_o (door_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      up_q    <= '0;
      down_q  <= '0;
      cab_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      down_q  <= down_d;
      cab_q   <= cab_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_q;
  assign move_up       = (state_q == ST_MOVING) && dir_q;
  assign move_down     = (state_q == ST_MOVING) && !dir_q;
  assign door_open     = in_door;
  assign lamp_up       = up_q[2:0];
  assign lamp_down     = down_q[3:1];
  assign lamp_cab      = cab_q;

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequencing controller for the 4-floor elevator car. Latches hall calls (up/down per floor) and cab calls into call registers, runs a collective-control state machine that drives the motor direction outputs, tracks the current floor from arrival pulses, and times the door. Sits between the hall/cab button decoders and the motor/door drivers.

## Interface
- DOOR_CYCLES, 16, clock cycles the door stays open after the last (re)start; ≥2
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hall_up  in  3  up-call buttons, floors 0..2 (bit i = floor i), level, sampled each cycle
- hall_down  in  3  down-call buttons, floors 1..3 (bit i = floor i+1)
- cab_call  in  4  car-panel buttons, floors 0..3
- arrive  in  1  one-cycle pulse from the shaft sensor: car reached the next floor
- door_obstruct  in  1  level; door sensor blocked
- current_floor  out  2  floor the car is at or last passed
- move_up, move_down  out  1  motor commands, mutually exclusive
- door_open  out  1  door command
- dir_up  out  1  travel direction flag (1 = up)
- lamp_up, lamp_down, lamp_cab  out  3/3/4  latched call registers, same bit mapping as inputs

## Operation
- States: IDLE, MOVING, DOOR_OPEN. All outputs decoded from registers only; no input-to-output combinational path.
- Call latching: any input bit high sets its lamp bit at the next edge; bits clear only when served. Exception: while in DOOR_OPEN, a cab call or a hall call in direction dir_up at current_floor is not latched and reloads the door timer.
- "Ahead" = any lamp bit at a floor strictly above (dir_up=1) or below (dir_up=0) current_floor.
- IDLE: no lamps → stay, dir_up held. Lamp at current_floor → DOOR_OPEN, clearing cab bit and hall bit matching dir_up; if only the opposite hall bit is set, flip dir_up and clear it. Else calls ahead → MOVING. Else calls behind → flip dir_up, MOVING.
- MOVING: move_up = dir_up, move_down = !dir_up. On arrive, current_floor ±1 at the same edge. Stop (→ DOOR_OPEN, move_* deasserted) if at new floor: cab bit set, or hall bit in travel direction set, or nothing ahead of new floor (end floors 0/3 always count as nothing ahead). Stop for the third reason: flip dir_up, clear the opposite-direction hall bit there. Clear cab bit and matching hall bit at stop. Otherwise remain MOVING.
- arrive outside MOVING is ignored. Car never moves above 3 or below 0.
- DOOR_OPEN: door_open=1, counter loads DOOR_CYCLES-1 on entry, decrements each cycle; door_obstruct high or suppressed call reloads it. Counter = 0 and no obstruct → IDLE, door_open=0.
- Counter width $clog2(DOOR_CYCLES); no wrap (reload dominates decrement).

## Timing
- Reset (async assert, sync release): IDLE, current_floor=0, dir_up=1, all lamps 0, move_*=0, door_open=0, counter 0.
- Button high at edge t → lamp set after t.
- IDLE → MOVING or DOOR_OPEN: one edge after the lamp becomes visible.
- arrive at edge t → current_floor and stop decision both take effect at t; move_* drop after t.
- Door open exactly DOOR_CYCLES cycles with no reloads; IDLE re-evaluates the following cycle.
- Simultaneous button and clear of the same bit: clear wins only for the served floor; the button is considered served.
- Reset mid-move or mid-door: immediate return to reset values; motor and door commands drop asynchronously.

## Structure
- Package elevator_pkg: state enum, FLOORS=4, floor type (2-bit), DIR_UP/DIR_DOWN constants.
- Sub-module door_timer: load/reload/decrement counter with done flag, parameter DOOR_CYCLES.
- Top contains call registers, ahead/behind reduction logic, FSM.

## Test plan
- Reset, cab_call=4'b1000 one cycle → lamp_cab=1000, move_up next cycle; 3 arrive pulses → floor 3, door_open for 16 cycles, lamp_cab=0.
- Car moving up from 0, hall_down[1] (floor 2) and cab_call[3] → passes floor 2, stops 3, reverses, stops 2, lamp_down cleared.
- At floor 1 door open, hall_up[1] pulse every 10 cycles → door stays open, lamp_up[1] stays 0; stop pulsing → closes 16 cycles later.
- door_obstruct held 40 cycles in DOOR_OPEN → door_open stays 1; release → closes after 16 cycles.
- arrive pulses in IDLE → current_floor unchanged at 0.
- Reset asserted mid-MOVING at floor 2 → move_up=0 immediately, floor 0, lamps cleared.
